// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: collects decimal digits, converts to binary on enter.
// Build option KEYPAD_AUTO_SUBMIT_EN: a digit that fills the buffer submits it.
module keypad_entry_buffer #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [3:0]                         selected_key,
  input  logic                               digit_pressed,
  input  logic                               backspace_pressed,
  input  logic                               enter_pressed,
  output logic [4*MAX_DIGITS-1:0]            digits_flat,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic                               busy,
  output logic                               entry_valid,
  output logic [VALUE_W-1:0]                 entry_value,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    entry_len,
  output logic                               overflow,
  output logic                               empty_enter,
  output logic                               dropped
);
  localparam int CW = $clog2(MAX_DIGITS+1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t                      state;
  logic [MAX_DIGITS-1:0][3:0]  digits;
  logic [CW-1:0]               count;
  logic [CW-1:0]               idx;
  logic [VALUE_W-1:0]          acc;

  logic                        anyPress;
  logic                        digitOk;
  logic                        full;
  logic                        lastIdx;
  logic [3:0]                  curDigit;
  logic [VALUE_W-1:0]          accNext;

  assign digits_flat = digits;
  assign digit_count = count;

  assign anyPress = digit_pressed | backspace_pressed | enter_pressed;
  assign digitOk  = digit_pressed && (selected_key <= 4'd9);
  assign full     = (count == CW'(MAX_DIGITS));
  assign lastIdx  = (idx == count - CW'(1));

  // Digit under conversion; a mux keeps the index width independent of depth.
  always_comb begin
    curDigit = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (CW'(i) == idx) curDigit = digits[i];
  end

  // acc*10 + digit as (acc<<3) + (acc<<1) + digit
  assign accNext = (acc << 3) + (acc << 1) + VALUE_W'(curDigit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      digits      <= '0;
      count       <= '0;
      idx         <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      entry_valid <= 1'b0;
      entry_value <= '0;
      entry_len   <= '0;
      overflow    <= 1'b0;
      empty_enter <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      overflow    <= 1'b0;
      empty_enter <= 1'b0;
      dropped     <= 1'b0;
      entry_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (enter_pressed) begin
              if (count == '0) begin
                empty_enter <= 1'b1;
              end else begin
                state <= CONVERT;
                busy  <= 1'b1;
                acc   <= '0;
                idx   <= '0;
              end
            end else if (backspace_pressed) begin
              if (count != '0) begin
                for (int i = 0; i < MAX_DIGITS; i++)
                  if (CW'(i) == count - CW'(1)) digits[i] <= 4'd0;
                count <= count - CW'(1);
              end
            end else if (digitOk) begin
              if (full) begin
                overflow <= 1'b1;
              end else begin
                for (int i = 0; i < MAX_DIGITS; i++)
                  if (CW'(i) == count) digits[i] <= selected_key;
                count <= count + CW'(1);
`ifdef KEYPAD_AUTO_SUBMIT_EN
                if (count == CW'(MAX_DIGITS-1)) begin
                  state <= CONVERT;
                  busy  <= 1'b1;
                  acc   <= '0;
                  idx   <= '0;
                end
`endif
              end
            end
          end
        end
        CONVERT: begin
          // Result is registered on the edge entering DONE so it lines up with DONE.
          dropped <= anyPress;
          acc     <= accNext;
          idx     <= idx + CW'(1);
          if (lastIdx) begin
            state       <= DONE;
            entry_valid <= 1'b1;
            entry_value <= accNext;
            entry_len   <= count;
          end
        end
        DONE: begin
          dropped <= anyPress;
          digits  <= '0;
          count   <= '0;
          idx     <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed sequences plus random events against
// a queue-based reference model.
module tb_keypad_entry_buffer;
  localparam int MAXD = 4;
  localparam int VW   = 14;
  localparam int CW   = $clog2(MAXD+1);

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [3:0]        selected_key;
  logic              digit_pressed, backspace_pressed, enter_pressed;
  logic [4*MAXD-1:0] digits_flat;
  logic [CW-1:0]     digit_count;
  logic              busy, entry_valid;
  logic [VW-1:0]     entry_value;
  logic [CW-1:0]     entry_len;
  logic              overflow, empty_enter, dropped;

  keypad_entry_buffer #(.MAX_DIGITS(MAXD), .VALUE_W(VW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .selected_key(selected_key),
    .digit_pressed(digit_pressed), .backspace_pressed(backspace_pressed),
    .enter_pressed(enter_pressed), .digits_flat(digits_flat),
    .digit_count(digit_count), .busy(busy), .entry_valid(entry_valid),
    .entry_value(entry_value), .entry_len(entry_len), .overflow(overflow),
    .empty_enter(empty_enter), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErr    = 0;

  // Reference model: digit queue, busy-cycle countdown, pending result.
  int q[$];
  int busyRem = 0, pendVal = 0, pendLen = 0, mVal = 0, mLen = 0;
  bit mOv = 0, mEe = 0, mDr = 0, mEv = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic submit();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    pendVal = v;
    pendLen = q.size();
    busyRem = pendLen + 1;
  endtask

  task automatic modelEdge(input bit r, input bit en, input bit d, input bit b,
                           input bit e, input int k);
    if (r) begin
      q.delete();
      busyRem = 0; mVal = 0; mLen = 0;
      mOv = 0; mEe = 0; mDr = 0; mEv = 0;
      return;
    end
    mOv = 0; mEe = 0; mDr = 0; mEv = 0;
    if (busyRem > 0) begin
      mDr = d | b | e;
      busyRem--;
      if (busyRem == 1) begin
        mEv = 1; mVal = pendVal; mLen = pendLen;
      end
      if (busyRem == 0) q.delete();
    end else if (en) begin
      if (e) begin
        if (q.size() == 0) mEe = 1; else submit();
      end else if (b) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (d && k <= 9) begin
        if (q.size() == MAXD) mOv = 1;
        else begin
          q.push_back(k);
`ifdef KEYPAD_AUTO_SUBMIT_EN
          if (q.size() == MAXD) submit();
`endif
        end
      end
    end
  endtask

  task automatic compareAll();
    logic [4*MAXD-1:0] expFlat = '0;
    foreach (q[i]) expFlat[4*i +: 4] = 4'(q[i]);
    chk("digits_flat", 64'(digits_flat), 64'(expFlat));
    chk("digit_count", 64'(digit_count), 64'(q.size()));
    chk("busy",        64'(busy),        64'(busyRem > 0));
    chk("entry_valid", 64'(entry_valid), 64'(mEv));
    chk("entry_value", 64'(entry_value), 64'(mVal));
    chk("entry_len",   64'(entry_len),   64'(mLen));
    chk("overflow",    64'(overflow),    64'(mOv));
    chk("empty_enter", 64'(empty_enter), 64'(mEe));
    chk("dropped",     64'(dropped),     64'(mDr));
  endtask

  task automatic step(input bit r, input bit en, input bit d, input bit b,
                      input bit e, input logic [3:0] k);
    reset = r; enable = en; digit_pressed = d; backspace_pressed = b;
    enter_pressed = e; selected_key = k;
    @(posedge clk);
    modelEdge(r, en, d, b, e, int'(k));
    #1;
    compareAll();
  endtask

  task automatic dig(input logic [3:0] k); step(0, 1, 1, 0, 0, k); endtask
  task automatic bsp();                    step(0, 1, 0, 1, 0, 4'd10); endtask
  task automatic ent();                    step(0, 1, 0, 0, 1, 4'd11); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 4'd0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 0, 4'd0);
    idle(1);
    // 1,2,3 enter
    dig(1); dig(2); dig(3); ent(); idle(6);
    // overflow / auto-submit
    dig(1); dig(2); dig(3); dig(4); dig(5); ent(); idle(8);
    // backspace editing
    dig(9); dig(8); bsp(); dig(7); ent(); idle(6);
    // empty buffer
    bsp(); ent(); idle(2);
    // press while busy, then enable low
    dig(4); dig(2); ent(); dig(5); idle(5);
    step(0, 0, 1, 0, 0, 4'd5); step(0, 0, 0, 0, 1, 4'd11); idle(2);
    // digit code above 9 is ignored
    step(0, 1, 1, 0, 0, 4'd10); idle(1);
    // reset mid-convert
    dig(9); dig(9); dig(9); dig(9); ent(); idle(1);
    step(1, 1, 0, 0, 0, 4'd0);
    dig(7); ent(); idle(4);
    // random events
    for (int n = 0; n < 4000; n++) begin
      int  sel = $urandom_range(0, 15);
      bit  en  = ($urandom_range(0, 9) != 0);
      bit  r   = ($urandom_range(0, 299) == 0);
      logic [3:0] k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3, 4: step(r, en, 1, 0, 0, k);
        5, 6:          step(r, en, 0, 1, 0, k);
        7:             step(r, en, 0, 0, 1, k);
        8:             step(r, en, 1'($urandom), 1'($urandom), 1'($urandom), k);
        default:       step(r, en, 0, 0, 0, k);
      endcase
    end
    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end
endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
- Consumer end of the keypad key-event interface. Accepts one-cycle digit/backspace/enter pulses plus the 4-bit key code, and accumulates a multi-digit entry (PIN / numeric field).
- On enter, converts the stored decimal digits to binary over several cycles, then emits a one-cycle result strobe.
- Sits between the keypad navigation logic and the application FSM (password check, numeric input). Also drives the digit display.

Parameters:
- MAX_DIGITS, 4, buffer depth in decimal digits (1..8).
- VALUE_W, 14, binary result width; must satisfy 2^VALUE_W > 10^MAX_DIGITS - 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  accept key events when high
- selected_key  in  4  key code, valid with a press pulse (0-9 digit, 10 backspace, 11 enter)
- digit_pressed  in  1  one-cycle digit event
- backspace_pressed  in  1  one-cycle backspace event
- enter_pressed  in  1  one-cycle enter event
- digits_flat  out  4*MAX_DIGITS  stored digits; digit i (i=0 first entered) at [4i+3:4i]; unused slots 0
- digit_count  out  $clog2(MAX_DIGITS+1)  number of stored digits
- busy  out  1  high in CONVERT and DONE
- entry_valid  out  1  one-cycle result strobe
- entry_value  out  VALUE_W  binary value of the submitted entry; holds until the next entry_valid
- entry_len  out  $clog2(MAX_DIGITS+1)  digit count of the submitted entry
- overflow  out  1  one-cycle pulse: digit rejected, buffer full
- empty_enter  out  1  one-cycle pulse: enter with empty buffer
- dropped  out  1  one-cycle pulse: event arrived while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; internal accumulator and index 0.
- States: IDLE (collect), CONVERT, DONE.
- IDLE, enable=1, evaluated on each clk edge. Priority is enter > backspace > digit if several pulses coincide.
  - digit: if count < MAX_DIGITS, store selected_key at slot count and increment count. Otherwise pulse overflow; buffer unchanged.
  - Digit pulse with selected_key > 9: ignored silently.
  - backspace: if count > 0, clear slot count-1 to 0 and decrement count. If count = 0, ignore; no flag.
  - enter: if count = 0, pulse empty_enter and stay in IDLE. Otherwise go to CONVERT with acc=0, idx=0.
- IDLE, enable=0: all events ignored, no flags.
- CONVERT: one digit per cycle, acc <= acc*10 + digit[idx] (implement x10 as shift-add), idx++. When idx = count-1, go to DONE.
- DONE (one cycle):
  - entry_valid=1, entry_value=acc, entry_len=count.
  - On exit: digits_flat and count cleared, state IDLE.
- Latency: enter sampled in cycle 0; entry_valid high in cycle count+1.
- digits_flat and digit_count stay stable through CONVERT for display.
- Any press pulse during CONVERT or DONE pulses dropped the next cycle and has no other effect. This holds regardless of enable. Dropping enable mid-CONVERT does not abort conversion.
- Flag pulses (overflow, empty_enter, dropped) are registered, one cycle after the causing event, and never stretched.
- Reset mid-CONVERT: abort immediately; no entry_valid; everything returns to reset values.
- Arithmetic never overflows by the VALUE_W constraint; no saturation logic.

Optional Feature:
- Macro: KEYPAD_AUTO_SUBMIT_EN.
- Defined: a digit that makes count = MAX_DIGITS also enters CONVERT on the same edge, exactly as if enter had been pressed; enter is unnecessary for a full buffer. An enter in IDLE with a partial buffer still works normally.
- Undefined: a full buffer waits in IDLE for enter; further digits pulse overflow.

Test Plan:
- Digits 1,2,3 then enter (MAX_DIGITS=4) -> digit_count 3 before enter, busy cycles 1-4, entry_valid in cycle 4 after enter with entry_value=123, entry_len=3; digits_flat=0 and digit_count=0 the cycle after.
- Digits 1,2,3,4,5 then enter -> overflow pulse after the 5th digit, entry_value=1234, entry_len=4; macro-defined build instead enters CONVERT on the 4th digit, entry_value=1234, and the 5th digit pulses dropped.
- Digits 9,8, backspace, 7, enter -> digit_count sequence 1,2,1,2; entry_value=97.
- Backspace then enter on an empty buffer -> digit_count stays 0, one empty_enter pulse, no entry_valid.
- Digit 5 pulsed during CONVERT of "42" -> dropped pulse, entry_value=42, buffer empty afterward; same digit with enable=0 in IDLE -> no change, no flags.
- Reset asserted in the 2nd CONVERT cycle of "9999" -> no entry_valid; all outputs 0 the cycle after reset; a new entry of 7 + enter yields entry_value=7.
